// File: rtl/sl_iter.sv
`default_nettype none
// ============================================================================
// Module   : sl_iter
// Brief    : Iterative 32-bit left shifter, one bit per clock, logical or
//            rotate mode, with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sl_iter (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] in,
   input  logic [4:0]  shamt,
   input  logic        rot,
   output logic [31:0] outp,
   output logic        carry,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_SHIFT = 2'd1;
   localparam logic [1:0] c_DONE  = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [31:0] r_wr;
   logic [4:0]  r_cnt;
   logic        r_rot;
   logic [31:0] r_outp;
   logic        r_carry;
   logic [31:0] w_shifted;
   logic        w_accept;
   logic        w_last;

   // In rotate mode the bit leaving position 31 re-enters at position 0.
   assign w_shifted = {r_wr[30:0], r_rot & r_wr[31]};
   assign w_accept  = (r_state == c_IDLE) && start;
   assign w_last    = (r_state == c_SHIFT) && (r_cnt == 5'd1);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (start) begin
               w_state_nxt = (shamt == 5'd0) ? c_DONE : c_SHIFT;
            end
         end
         c_SHIFT: begin
            if (r_cnt == 5'd1) begin
               w_state_nxt = c_DONE;
            end
         end
         c_DONE: begin
            w_state_nxt = c_IDLE;
         end
         default: begin
            w_state_nxt = c_IDLE;
         end
      endcase
   end

   // Output decode
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         c_IDLE: begin
            busy = 1'b0;
         end
         c_SHIFT: begin
            busy = 1'b1;
         end
         c_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Datapath: working register, counter, mode and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr    <= 32'd0;
         r_cnt   <= 5'd0;
         r_rot   <= 1'b0;
         r_outp  <= 32'd0;
         r_carry <= 1'b0;
      end else if (w_accept) begin
         r_wr  <= in;
         r_cnt <= shamt;
         r_rot <= rot;
         if (shamt == 5'd0) begin
            r_outp  <= in;
            r_carry <= 1'b0;
         end
      end else if (r_state == c_SHIFT) begin
         r_wr    <= w_shifted;
         r_cnt   <= r_cnt - 5'd1;
         r_carry <= r_wr[31];
         if (w_last) begin
            r_outp <= w_shifted;
         end
      end
   end

   assign outp  = r_outp;
   assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_sl_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sl_iter
// Brief    : Directed self-checking bench for sl_iter with result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sl_iter;

   typedef struct packed {
      logic [31:0] o;
      logic        c;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] in_d;
   logic [4:0]  shamt_d;
   logic        rot_d;
   logic [31:0] outp;
   logic        carry;
   logic        busy;
   logic        done;

   int   n_cmp;
   int   n_mis;
   int   n_done;
   exp_t sb_q[$];

   sl_iter u_dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .in    (in_d),
      .shamt (shamt_d),
      .rot   (rot_d),
      .outp  (outp),
      .carry (carry),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: 64-bit widened shift; the upper half holds the bits pushed out.
   function automatic exp_t model(input logic [31:0] a, input logic [4:0] s, input logic r);
      exp_t        e;
      logic [63:0] w;
      w   = {32'd0, a} << s;
      e.o = w[31:0] | (r ? w[63:32] : 32'd0);
      e.c = w[32];
      return e;
   endfunction

   // Scoreboard: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         n_done++;
         if (sb_q.size() == 0) begin
            chk("unexpected_done", {63'd0, done}, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_outp", {32'd0, outp}, {32'd0, e.o});
            chk("sb_carry", {63'd0, carry}, {63'd0, e.c});
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic r,
                         input logic [31:0] eo, input logic ec);
      int lat;
      @(negedge clk);
      in_d    = a;
      shamt_d = s;
      rot_d   = r;
      start   = 1'b1;
      sb_q.push_back(model(a, s, r));
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      chk("busy_rise", {63'd0, busy}, 64'd1);
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, int'(s) + 1);
      chk("busy_in_done", {63'd0, busy}, 64'd1);
      chk("outp_const", {32'd0, outp}, {32'd0, eo});
      chk("carry_const", {63'd0, carry}, {63'd0, ec});
      @(negedge clk);
      chk("done_pulse", {63'd0, done}, 64'd0);
      chk("busy_fall", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      int   n_before;
      exp_t e;
      n_cmp   = 0;
      n_mis   = 0;
      n_done  = 0;
      reset   = 1'b1;
      start   = 1'b0;
      in_d    = 32'd0;
      shamt_d = 5'd0;
      rot_d   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outp", {32'd0, outp}, 64'd0);
      chk("rst_carry", {63'd0, carry}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      // Reset wins over a simultaneous start.
      start = 1'b1;
      @(negedge clk);
      chk("rst_prio_busy", {63'd0, busy}, 64'd0);
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      run_op(32'h00000001, 5'd4, 1'b0, 32'h00000010, 1'b0);
      run_op(32'h80000001, 5'd1, 1'b1, 32'h00000003, 1'b1);
      run_op(32'hDEADBEEF, 5'd0, 1'b0, 32'hDEADBEEF, 1'b0);

      // Maximum shift with start pulses ignored while busy (including DONE).
      n_before = n_done;
      @(negedge clk);
      in_d    = 32'hFFFFFFFF;
      shamt_d = 5'd31;
      rot_d   = 1'b0;
      start   = 1'b1;
      sb_q.push_back(model(32'hFFFFFFFF, 5'd31, 1'b0));
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         in_d    = 32'h12345678;
         shamt_d = 5'd3;
         rot_d   = 1'b1;
         start   = (lat % 2 == 1) || (done === 1'b1);
      end while (done !== 1'b1 && lat < 40);
      chk("t4_latency", lat, 32);
      chk("t4_outp", {32'd0, outp}, 64'h80000000);
      chk("t4_carry", {63'd0, carry}, 64'd1);
      @(negedge clk);
      start = 1'b0;
      chk("t4_busy_fall", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clk);
      chk("t4_one_done", n_done - n_before, 1);
      chk("t4_outp_hold", {32'd0, outp}, 64'h80000000);

      // Reset during the third SHIFT cycle aborts the operation.
      n_before = n_done;
      @(negedge clk);
      in_d    = 32'hA5A5A5A5;
      shamt_d = 5'd10;
      rot_d   = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("t5_outp_retain", {32'd0, outp}, 64'h80000000);
      chk("t5_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t5_busy_rst", {63'd0, busy}, 64'd0);
      chk("t5_outp_rst", {32'd0, outp}, 64'd0);
      chk("t5_carry_rst", {63'd0, carry}, 64'd0);
      repeat (12) @(negedge clk);
      chk("t5_no_done", n_done - n_before, 0);
      run_op(32'h0000000F, 5'd8, 1'b1, 32'h00000F00, 1'b0);

      // Back-to-back with start held high.
      n_before = n_done;
      @(negedge clk);
      in_d    = 32'h1;
      shamt_d = 5'd2;
      rot_d   = 1'b0;
      start   = 1'b1;
      sb_q.push_back(model(32'h1, 5'd2, 1'b0));
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (done !== 1'b1 && lat < 40);
      chk("t6_lat1", lat, 3);
      chk("t6_outp1", {32'd0, outp}, 64'h4);
      in_d    = 32'h3;
      shamt_d = 5'd3;
      rot_d   = 1'b0;
      sb_q.push_back(model(32'h3, 5'd3, 1'b0));
      @(negedge clk);
      chk("t6_idle_gap", {63'd0, busy}, 64'd0);
      chk("t6_done_low", {63'd0, done}, 64'd0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (done !== 1'b1 && lat < 40);
      chk("t6_lat2", lat, 4);
      chk("t6_outp2", {32'd0, outp}, 64'h18);
      start = 1'b0;
      @(negedge clk);
      chk("t6_busy_fall", {63'd0, busy}, 64'd0);
      repeat (2) @(negedge clk);
      chk("t6_two_done", n_done - n_before, 2);

      // A few random operations checked against the model.
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         logic [4:0]  s;
         logic        r;
         a = $urandom;
         s = 5'($urandom_range(1, 31));
         r = 1'($urandom_range(0, 1));
         e = model(a, s, r);
         run_op(a, s, r, e.o, e.c);
      end

      repeat (2) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
